gshare_predictor: RTL and testbench

//  Parametrised gshare conditional-branch direction predictor for the fetch/decode front end.

---
 rtl/gshare_predictor.sv | 137 +++++++++++++
 tb/tb_gshare_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare branch direction predictor.
// A table of 2-bit saturating counters is indexed by PC bits XOR the
// speculative global history. Predictions are combinational at fetch.
// Resolved branches train the table from execute. A mispredict restores
// the history from the checkpoint that travelled down the pipe.
module gshare_predictor #(
  parameter int         INDEX_BITS = 8,
  parameter int         HIST_BITS  = 8,
  parameter int         PC_LSB     = 2,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [HIST_BITS-1:0]  upd_ghr
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0]  spec_ghr_q, spec_ghr_d;
  logic [1:0]            pht_q [ENTRIES];

  logic                  run;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [HIST_BITS-1:0]  ghr_shifted;
  logic [HIST_BITS-1:0]  ghr_restored;
  logic [1:0]            upd_ctr;
  logic [1:0]            upd_ctr_next;
  logic                  unused_bits;

  // Only part of the PC (and, for a 1-bit history, none of the checkpoint) feeds the index.
  assign unused_bits = ^{pred_pc, upd_ghr};

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Zero-extend the history to index width so it can be XORed with the PC bits.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[HIST_BITS-1:0] = spec_ghr_q;
  end

  assign lookup_idx = pred_pc[PC_LSB +: INDEX_BITS] ^ ghr_ext;
  assign pred_index = lookup_idx;
  assign pred_ghr   = spec_ghr_q;
  assign pred_taken = run & pht_q[lookup_idx][1];

  // Build the shifted-in and restored histories; a 1-bit history has no older bits to keep.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shifted  = pred_taken;
      assign ghr_restored = upd_taken;
    end else begin : g_histn
      assign ghr_shifted  = {spec_ghr_q[HIST_BITS-2:0], pred_taken};
      assign ghr_restored = {upd_ghr[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // Sweep the table once after reset, then stay in RUN until the next reset.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (&init_ptr_q) begin
        state_d = ST_RUN;
      end
    end
  end

  // A mispredict restore wins over a same-cycle fetch shift, since that fetch is squashed.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (run) begin
      if (upd_valid && upd_mispredict) begin
        spec_ghr_d = ghr_restored;
      end else if (pred_valid) begin
        spec_ghr_d = ghr_shifted;
      end
    end
  end

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    upd_ctr      = pht_q[upd_index];
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'b11) begin
        upd_ctr_next = upd_ctr + 2'b01;
      end
    end else begin
      if (upd_ctr != 2'b00) begin
        upd_ctr_next = upd_ctr - 2'b01;
      end
    end
  end

  // Control state and speculative history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      spec_ghr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      spec_ghr_q <= spec_ghr_d;
    end
  end

  // Counter table: written by the init sweep, otherwise by the single update port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        pht_q[init_ptr_q] <= CTR_INIT;
      end else if (upd_valid) begin
        pht_q[upd_index] <= upd_ctr_next;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed self-checking bench for gshare_predictor.
module tb_gshare_predictor;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [7:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [7:0]  upd_ghr;

  int assertCount = 0;
  int failCount   = 0;
  int edges;

  gshare_predictor #(
    .INDEX_BITS(8),
    .HIST_BITS (8),
    .PC_LSB    (2),
    .CTR_INIT  (2'b01)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_index    (pred_index),
    .pred_ghr      (pred_ghr),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_taken     (upd_taken),
    .upd_mispredict(upd_mispredict),
    .upd_ghr       (upd_ghr)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic uv,
                               input logic [7:0] uidx, input logic ut, input logic um,
                               input logic [7:0] ughr);
    pred_valid     = pv;
    pred_pc        = pc;
    upd_valid      = uv;
    upd_index      = uidx;
    upd_taken      = ut;
    upd_mispredict = um;
    upd_ghr        = ughr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Lookup with no fetch and no update, so nothing changes at the next edge.
  task automatic peek(input string tag, input logic [31:0] pc, input logic expTaken);
    applyStimulus(1'b0, pc, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput(tag, {31'b0, pred_taken}, {31'b0, expTaken});
  endtask

  task automatic train(input logic [7:0] idx, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, idx, taken, 1'b0, 8'h00);
      tick();
    end
    idle();
  endtask

  // Pulse reset and count edges until ready rises.
  task automatic resetAndInit(input string tag);
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    checkOutput({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
    edges = 0;
    while (!ready && edges < 400) begin
      tick();
      edges++;
    end
    checkOutput({tag, "_sweep_len"}, edges, 32'd256);
  endtask

  // Directed scenario sequence.
  initial begin
    rst = 1'b1;
    idle();

    resetAndInit("init1");

    peek("idx5_init", 32'h14, 1'b0);
    checkOutput("idx5_index", {24'b0, pred_index}, 32'h05);
    checkOutput("idx5_ghr", {24'b0, pred_ghr}, 32'h00);

    train(8'h05, 1'b1, 2);
    peek("idx5_trained", 32'h14, 1'b1);

    train(8'h09, 1'b1, 5);
    peek("sat_top", 32'h24, 1'b1);
    train(8'h09, 1'b0, 1);
    peek("sat_top_dec", 32'h24, 1'b1);
    train(8'h09, 1'b0, 3);
    peek("sat_bottom", 32'h24, 1'b0);
    train(8'h09, 1'b0, 1);
    train(8'h09, 1'b1, 1);
    peek("sat_no_wrap", 32'h24, 1'b0);
    train(8'h09, 1'b1, 1);
    peek("sat_recover", 32'h24, 1'b1);

    applyStimulus(1'b1, 32'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("ghr_p0", {31'b0, pred_taken}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h14, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("ghr_p1", {31'b0, pred_taken}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("ghr_p2_index", {24'b0, pred_index}, 32'h05);
    checkOutput("ghr_p2", {31'b0, pred_taken}, 32'd1);
    tick();
    idle();
    checkOutput("ghr_after3", {24'b0, pred_ghr}, 32'h03);

    applyStimulus(1'b0, 32'h0, 1'b1, 8'h10, 1'b0, 1'b1, 8'hA0);
    tick();
    idle();
    checkOutput("ghr_restore", {24'b0, pred_ghr}, 32'h40);

    applyStimulus(1'b1, 32'h11C, 1'b1, 8'h07, 1'b1, 1'b0, 8'h00);
    checkOutput("same_idx", {24'b0, pred_index}, 32'h07);
    checkOutput("same_no_bypass", {31'b0, pred_taken}, 32'd0);
    tick();
    idle();
    checkOutput("same_ghr", {24'b0, pred_ghr}, 32'h80);
    peek("same_next", 32'h21C, 1'b1);

    applyStimulus(1'b1, 32'h214, 1'b1, 8'h05, 1'b1, 1'b1, 8'h0F);
    checkOutput("prio_pred", {31'b0, pred_taken}, 32'd1);
    tick();
    idle();
    checkOutput("prio_ghr", {24'b0, pred_ghr}, 32'h1F);

    applyStimulus(1'b0, 32'h0, 1'b0, 8'h05, 1'b0, 1'b1, 8'h55);
    tick();
    idle();
    checkOutput("mispred_qual", {24'b0, pred_ghr}, 32'h1F);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    applyStimulus(1'b1, 32'h14, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("init_pred_gate", {31'b0, pred_taken}, 32'd0);
    checkOutput("init_ghr_reset", {24'b0, pred_ghr}, 32'h00);
    checkOutput("init_ready", {31'b0, ready}, 32'd0);
    idle();
    for (int i = 2; i < 100; i++) begin
      tick();
    end
    rst = 1'b1;
    tick();
    checkOutput("midsweep_ready", {31'b0, ready}, 32'd0);
    rst = 1'b0;
    edges = 0;
    while (!ready && edges < 400) begin
      if (edges == 4) begin
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
      end
      tick();
      edges++;
    end
    idle();
    checkOutput("restart_sweep_len", edges, 32'd256);

    for (int i = 0; i < 256; i += 17) begin
      peek($sformatf("reinit_%0d", i), 32'(i) << 2, 1'b0);
    end
    train(8'h05, 1'b1, 1);
    peek("reinit_val5", 32'h14, 1'b1);
    train(8'h07, 1'b1, 1);
    peek("reinit_val7", 32'h1C, 1'b1);
    train(8'h03, 1'b1, 1);
    peek("init_upd_ignored", 32'h0C, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
